// File: rtl/xcvr_test_pkg.sv
// Shared definitions for the transceiver clock monitors.
//   mon_state_e : monitor FSM state encoding (IDLE / MEASURE)
//   gate_cnt_w  : width of a gate counter that runs 0..gate_cycles-1
package xcvr_test_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } mon_state_e;

  // clog2 of the window length, never narrower than one bit.
  function automatic int gate_cnt_w(input int gate_cycles);
    int w;
    w = $clog2(gate_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/xcvr_sync_edge_det.sv
// Brings an asynchronous clock sample into the clk domain and flags its
// rising edges.
//   clk        : sampling clock
//   reset_n    : asynchronous active-low reset
//   async_in   : asynchronous input (sampled transceiver clock)
//   rise_pulse : one-cycle pulse per detected rising edge of async_in
module xcvr_sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  // The pulse is counted on the third clk edge after the pin changes.
  assign rise_pulse = sync_q2 & ~prev_q;

endmodule

// File: rtl/xcvr_clkout2_freq_monitor.sv
// Frequency monitor for the transceiver clkout2: counts rising edges of the
// sampled clock over back-to-back windows of GATE_CYCLES clk cycles and
// qualifies the frequency after two consecutive in-range windows.
//   clk            : management/reference clock
//   reset_n        : asynchronous active-low reset
//   enable         : run measurements while high
//   clkout2_sample : sampled transceiver clock, asynchronous to clk
//   count          : edge count of the last completed window
//   count_valid    : one-cycle pulse when count updates
//   clock_present  : last completed window saw at least one edge
//   overflow       : last completed window saturated the edge counter
//   freq_ok        : two consecutive good windows seen, no bad one since
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | not measuring; counters held at zero
// ST_MEASURE | window running; gate counter 0..GATE_CYCLES-1, edges counted
module xcvr_clkout2_freq_monitor
  import xcvr_test_pkg::*;
#(
  parameter int GATE_CYCLES = 10000,
  parameter int CNT_W       = 16,
  parameter int MIN_COUNT   = 0,
  parameter int MAX_COUNT   = (2 ** CNT_W) - 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clkout2_sample,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             clock_present,
  output logic             overflow,
  output logic             freq_ok
);

  localparam int               GW        = gate_cnt_w(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  mon_state_e       state_q;
  mon_state_e       state_d;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] edge_q;
  logic             win_ovf_q;
  logic             good_streak_q;

  logic             edge_pulse;
  logic             in_measure;
  logic             window_end;
  logic [CNT_W-1:0] edge_final;
  logic             ovf_final;
  logic             window_good;
  logic [CNT_W-1:0] min_lim;
  logic [CNT_W-1:0] max_lim;

  xcvr_sync_edge_det u_sync_edge_det (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (clkout2_sample),
    .rise_pulse (edge_pulse)
  );

  // Limits as nets so the range test stays a plain compare for any limit,
  // including a lower bound of zero.
  assign min_lim = CNT_W'(MIN_COUNT);
  assign max_lim = CNT_W'(MAX_COUNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enable)  state_d = ST_MEASURE;
      ST_MEASURE: if (!enable) state_d = ST_IDLE;
    endcase
  end

  assign in_measure = (state_q == ST_MEASURE) && enable;
  assign window_end = in_measure && (gate_q == GATE_LAST);

  // Edge of the current cycle folded in, so the last gate cycle's edge
  // lands in the closing window.
  assign edge_final  = (edge_pulse && (edge_q != CNT_SAT)) ? edge_q + 1'b1 : edge_q;
  assign ovf_final   = win_ovf_q | (edge_final == CNT_SAT);
  assign window_good = (edge_final >= min_lim) && (edge_final <= max_lim) && !ovf_final;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_q        <= '0;
      edge_q        <= '0;
      win_ovf_q     <= 1'b0;
      good_streak_q <= 1'b0;
      count         <= '0;
      count_valid   <= 1'b0;
      clock_present <= 1'b0;
      overflow      <= 1'b0;
      freq_ok       <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (in_measure) begin
        if (window_end) begin
          gate_q        <= '0;
          edge_q        <= '0;
          win_ovf_q     <= 1'b0;
          count         <= edge_final;
          overflow      <= ovf_final;
          clock_present <= (edge_final != '0);
          count_valid   <= 1'b1;
          if (window_good) begin
            freq_ok       <= good_streak_q;
            good_streak_q <= 1'b1;
          end else begin
            freq_ok       <= 1'b0;
            good_streak_q <= 1'b0;
          end
        end else begin
          gate_q    <= gate_q + 1'b1;
          edge_q    <= edge_final;
          win_ovf_q <= ovf_final;
        end
      end else begin
        gate_q    <= '0;
        edge_q    <= '0;
        win_ovf_q <= 1'b0;
        // Leaving MEASURE abandons the window and the qualification.
        if (state_q == ST_MEASURE) begin
          freq_ok       <= 1'b0;
          good_streak_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xcvr_clkout2_freq_monitor.sv
// Directed bench for xcvr_clkout2_freq_monitor. Instance A: 100-cycle window,
// range 24..26, 25 MHz sample. Instance B: 4-bit counter, sample at clk/3.
module tb_xcvr_clkout2_freq_monitor;

  logic        clk;
  logic        reset_n;
  logic        en_a;
  logic        en_b;
  logic        run_a;
  logic        man_a;
  logic        man_val_a;
  logic        osc_a;
  logic        osc_b;
  logic        sample_a;

  logic [15:0] count_a;
  logic        cv_a;
  logic        cp_a;
  logic        ovf_a;
  logic        fok_a;
  logic [3:0]  count_b;
  logic        cv_b;
  logic        cp_b;
  logic        ovf_b;
  logic        fok_b;

  int checks = 0;
  int errors = 0;
  int n;
  int cv_seen;

  assign sample_a = man_a ? man_val_a : osc_a;

  xcvr_clkout2_freq_monitor #(
    .GATE_CYCLES (100),
    .CNT_W       (16),
    .MIN_COUNT   (24),
    .MAX_COUNT   (26)
  ) dut_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (en_a),
    .clkout2_sample (sample_a),
    .count          (count_a),
    .count_valid    (cv_a),
    .clock_present  (cp_a),
    .overflow       (ovf_a),
    .freq_ok        (fok_a)
  );

  xcvr_clkout2_freq_monitor #(
    .GATE_CYCLES (100),
    .CNT_W       (4)
  ) dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (en_b),
    .clkout2_sample (osc_b),
    .count          (count_b),
    .count_valid    (cv_b),
    .clock_present  (cp_b),
    .overflow       (ovf_b),
    .freq_ok        (fok_b)
  );

  // 100 MHz clk, rising edges at 5 + 10k ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 25 MHz sample, transitions at 2 mod 10 ns, forced low when stopped.
  initial begin
    osc_a = 1'b0;
    #2;
    forever begin
      #20;
      osc_a = run_a ? ~osc_a : 1'b0;
    end
  end

  // clk/3 sample, high 10 ns of every 30 ns, transitions at 3 mod 10 ns.
  initial begin
    osc_b = 1'b0;
    #3;
    forever begin
      osc_b = 1'b1;
      #10;
      osc_b = 1'b0;
      #20;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until the selected count_valid is seen; returns the tick count,
  // or budget+1 on timeout so the following latency check fails.
  task automatic wait_cv(input bit sel_b, input int budget, output int cnt);
    cnt = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (sel_b ? cv_b : cv_a) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    run_a     = 1'b0;
    man_a     = 1'b0;
    man_val_a = 1'b0;

    #1;
    check("rst_count",   32'(count_a), 0);
    check("rst_cv",      32'(cv_a),    0);
    check("rst_present", 32'(cp_a),    0);
    check("rst_ovf",     32'(ovf_a),   0);
    check("rst_freq_ok", 32'(fok_a),   0);

    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Saturation: 33-34 edges into a 4-bit counter.
    en_b = 1'b1;
    wait_cv(1'b1, 200, n);
    check("b_first_latency", n, 101);
    check("b_count_sat",     32'(count_b), 15);
    check("b_overflow",      32'(ovf_b),   1);
    check("b_present",       32'(cp_b),    1);
    check("b_freq_ok",       32'(fok_b),   0);
    wait_cv(1'b1, 150, n);
    check("b_period",        n, 100);
    check("b_overflow2",     32'(ovf_b),   1);
    check("b_freq_ok2",      32'(fok_b),   0);
    en_b = 1'b0;

    // Nominal 25 MHz: 25 edges per window, qualified on the second window.
    run_a = 1'b1;
    repeat (5) tick();
    en_a = 1'b1;
    wait_cv(1'b0, 200, n);
    check("a_first_latency", n, 101);
    check("a_count1",        32'(count_a), 25);
    check("a_present1",      32'(cp_a),    1);
    check("a_ovf1",          32'(ovf_a),   0);
    check("a_freq_ok1",      32'(fok_a),   0);
    tick();
    check("a_cv_one_cycle",  32'(cv_a),    0);
    wait_cv(1'b0, 150, n);
    check("a_period2",       n, 99);
    check("a_count2",        32'(count_a), 25);
    check("a_freq_ok2",      32'(fok_a),   1);
    wait_cv(1'b0, 150, n);
    check("a_period3",       n, 100);
    check("a_count3",        32'(count_a), 25);
    check("a_freq_ok3",      32'(fok_a),   1);

    // Sample stopped: partial window is bad, next full window is empty.
    run_a = 1'b0;
    wait_cv(1'b0, 150, n);
    check("stop_period",     n, 100);
    check("stop_freq_ok",    32'(fok_a),   0);
    wait_cv(1'b0, 150, n);
    check("dead_count",      32'(count_a), 0);
    check("dead_present",    32'(cp_a),    0);
    check("dead_ovf",        32'(ovf_a),   0);
    check("dead_freq_ok",    32'(fok_a),   0);

    // Requalify, then drop enable at gate cycle 50.
    run_a = 1'b1;
    repeat (3) wait_cv(1'b0, 150, n);
    check("requal_count",    32'(count_a), 25);
    check("requal_freq_ok",  32'(fok_a),   1);
    repeat (50) tick();
    en_a = 1'b0;
    tick();
    check("drop_freq_ok",    32'(fok_a),   0);
    cv_seen = 0;
    repeat (120) begin
      tick();
      if (cv_a) cv_seen++;
    end
    check("drop_no_cv",      cv_seen, 0);
    check("drop_count_hold", 32'(count_a), 25);
    check("drop_present",    32'(cp_a),    1);
    // enable is sampled on the next edge; the window then takes 100 cycles.
    en_a = 1'b1;
    wait_cv(1'b0, 200, n);
    check("reen_latency",    n, 101);
    check("reen_count",      32'(count_a), 25);
    check("reen_freq_ok",    32'(fok_a),   0);
    wait_cv(1'b0, 150, n);
    check("reen_freq_ok2",   32'(fok_a),   1);

    // Reset mid-window clears outputs without a clk edge.
    repeat (30) tick();
    reset_n = 1'b0;
    #2;
    check("mrst_count",      32'(count_a), 0);
    check("mrst_present",    32'(cp_a),    0);
    check("mrst_ovf",        32'(ovf_a),   0);
    check("mrst_freq_ok",    32'(fok_a),   0);
    check("mrst_cv",         32'(cv_a),    0);
    check("mrst_b_count",    32'(count_b), 0);
    check("mrst_b_ovf",      32'(ovf_b),   0);
    tick();
    reset_n = 1'b1;
    wait_cv(1'b0, 200, n);
    check("mrst_latency",    n, 101);
    check("mrst_count2",     32'(count_a), 25);

    // Edge landing on gate cycle 99 belongs to the closing window.
    man_a     = 1'b1;
    man_val_a = 1'b0;
    wait_cv(1'b0, 150, n);
    check("man_period",      n, 100);
    repeat (97) tick();
    man_val_a = 1'b1;
    wait_cv(1'b0, 150, n);
    check("g99_latency",     n, 3);
    check("g99_count",       32'(count_a), 1);
    check("g99_present",     32'(cp_a),    1);
    wait_cv(1'b0, 150, n);
    check("g99_next_count",  32'(count_a), 0);
    check("g99_next_pres",   32'(cp_a),    0);

    // One cycle later the edge falls on gate cycle 0 of the next window.
    man_val_a = 1'b0;
    repeat (98) tick();
    man_val_a = 1'b1;
    wait_cv(1'b0, 150, n);
    check("g0_latency",      n, 2);
    check("g0_prev_count",   32'(count_a), 0);
    wait_cv(1'b0, 150, n);
    check("g0_count",        32'(count_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
